instruction_fetch_queue: RTL and testbench

Decoupled fetch stage that sits directly upstream of the IF/ID pipeline register. It drives a request/grant instruction-memory port and tracks the fetch PC. Fetched instructions and their PCs are buffered in a DEPTH-entry FIFO and presented to IF/ID with a valid/ready handshake. A taken-branch redirect from EX/MEM flushes the queue and discards any in-flight wrong-path responses.

---
 rtl/instruction_fetch_queue.sv | 122 ++++++++++++
 tb/tb_instruction_fetch_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_queue.sv
// Decoupled fetch stage: credit-limited imem request port feeding a DEPTH-entry
// instruction/PC FIFO toward IF/ID; a redirect flushes and drops wrong-path responses.
module instruction_fetch_queue #(
    parameter int unsigned      DEPTH    = 4,
    parameter int unsigned      XLEN     = 64,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [XLEN-1:0]            imem_addr,
    input  logic                       imem_gnt,
    input  logic                       imem_rvalid,
    input  logic [31:0]                imem_rdata,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_inst,
    output logic [XLEN-1:0]            out_pc,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0]      inst_mem_q [DEPTH];
    logic [XLEN-1:0]  pc_mem_q   [DEPTH];

    logic credit_ok;
    logic grant;
    logic push;
    logic pop;

    // Requests in flight count against FIFO space so a push can never overflow.
    assign credit_ok = (SUM_W'(count_q) + SUM_W'(outst_q)) < SUM_W'(DEPTH);
    assign imem_req  = reset && !redirect && credit_ok;
    assign imem_addr = fetch_pc_q;
    assign grant     = imem_req && imem_gnt;
    assign push      = imem_rvalid && !redirect && (drop_q == '0);
    assign pop       = out_valid && out_ready && !redirect;

    assign out_valid = (count_q != '0);
    assign out_inst  = inst_mem_q[rd_ptr_q];
    assign out_pc    = pc_mem_q[rd_ptr_q];
    assign occupancy = count_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        outst_d    = outst_q - CNT_W'(imem_rvalid);
        drop_d     = drop_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        if (redirect) begin
            // Everything still outstanding belongs to the old stream, including
            // anything already marked for dropping by an earlier redirect.
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            drop_d     = outst_q - CNT_W'(imem_rvalid);
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
                outst_d    = outst_q + CNT_W'(1) - CNT_W'(imem_rvalid);
            end
            if (imem_rvalid && (drop_q != '0)) begin
                drop_d = drop_q - CNT_W'(1);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + XLEN'(4);
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Storage has no reset; validity is carried entirely by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]   <= resp_pc_q;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Randomized bench for instruction_fetch_queue: an in-order memory model with
// variable latency plus an epoch-tagged queue model of the expected output stream.
module tb_instruction_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             reset;
    logic             imem_req;
    logic [XLEN-1:0]  imem_addr;
    logic             imem_gnt;
    logic             imem_rvalid;
    logic [31:0]      imem_rdata;
    logic             redirect;
    logic [XLEN-1:0]  redirect_pc;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_inst;
    logic [XLEN-1:0]  out_pc;
    logic [OCC_W-1:0] occupancy;

    instruction_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .RESET_PC('0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [63:0] pc; int epoch; }        req_t;
    typedef struct { logic [31:0] inst; logic [63:0] pc; } ent_t;
    typedef struct { logic [63:0] addr; longint due; }     rsp_t;

    req_t        outst_m[$];
    ent_t        fifo_m[$];
    rsp_t        mem_q[$];
    logic [63:0] fetch_pc_m;
    int          epoch_m;
    longint      cyc;
    longint      last_due;

    int unsigned lat_min, lat_max, gnt_pct, rdy_pct;
    int          n_cmp, n_err;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b0;
        outst_m.delete();
        fifo_m.delete();
        mem_q.delete();
        fetch_pc_m = '0;
        epoch_m++;
        #1;
        check_eq("rst_imem_req", 64'(imem_req), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_occupancy", 64'(occupancy), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("rel_imem_req", 64'(imem_req), 64'd1);
        check_eq("rel_imem_addr", imem_addr, 64'd0);
        last_due = cyc;
    endtask

    // One clock: drive inputs, compare DUT against the model, then advance the model.
    task automatic step(input bit redir, input logic [63:0] rpc);
        logic   exp_req;
        bit     rv;
        req_t   r;
        longint due;
        @(negedge clk);
        redirect    = redir;
        redirect_pc = rpc;
        out_ready   = ($urandom_range(99) < rdy_pct);
        imem_gnt    = ($urandom_range(99) < gnt_pct);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        rv          = 1'b0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            rv          = 1'b1;
            imem_rvalid = 1'b1;
            imem_rdata  = mem_q[0].addr[31:0];
            void'(mem_q.pop_front());
        end
        #1;
        exp_req = !redir && ((fifo_m.size() + outst_m.size()) < DEPTH);
        check_eq("imem_req", 64'(imem_req), 64'(exp_req));
        check_eq("imem_addr", imem_addr, fetch_pc_m);
        check_eq("out_valid", 64'(out_valid), 64'(fifo_m.size() > 0));
        check_eq("occupancy", 64'(occupancy), 64'(fifo_m.size()));
        if (fifo_m.size() > 0) begin
            check_eq("out_pc", out_pc, fifo_m[0].pc);
            check_eq("out_inst", 64'(out_inst), 64'(fifo_m[0].inst));
        end

        r = '{pc: '0, epoch: -1};
        if (rv) r = outst_m.pop_front();
        if (redir) begin
            fifo_m.delete();
            fetch_pc_m = rpc;
            epoch_m++;
        end else begin
            if (fifo_m.size() > 0 && out_ready) void'(fifo_m.pop_front());
            if (rv && r.epoch == epoch_m) fifo_m.push_back('{inst: r.pc[31:0], pc: r.pc});
            if (exp_req && imem_gnt) begin
                outst_m.push_back('{pc: fetch_pc_m, epoch: epoch_m});
                due = cyc + longint'($urandom_range(lat_max, lat_min));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mem_q.push_back('{addr: fetch_pc_m, due: due});
                fetch_pc_m = fetch_pc_m + 64'd4;
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; last_due = 0; epoch_m = 0;
        reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0; fetch_pc_m = '0;
        lat_min = 1; lat_max = 1; gnt_pct = 100; rdy_pct = 100;
        apply_reset();

        // Free run, single-cycle memory
        run(20);
        // Backpressure: queue fills, requests stop, head holds
        rdy_pct = 0;
        run(10);
        rdy_pct = 100;
        run(10);
        // Redirect with responses in flight
        lat_min = 2; lat_max = 2;
        run(6);
        step(1'b1, 64'h100);
        run(10);
        // Redirect coincident with response and pop
        lat_min = 1; lat_max = 1;
        run(5);
        step(1'b1, 64'h180);
        run(8);
        // Back-to-back redirects, slow memory
        lat_min = 3; lat_max = 3;
        run(8);
        step(1'b1, 64'h200);
        step(1'b1, 64'h300);
        run(15);
        // PC wraparound
        lat_min = 1; lat_max = 1;
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        run(10);
        // Mid-operation reset
        run(3);
        apply_reset();
        run(10);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                lat_min = $urandom_range(2, 1);
                lat_max = lat_min + $urandom_range(3);
                gnt_pct = $urandom_range(100, 30);
                rdy_pct = $urandom_range(100, 20);
            end
            if ($urandom_range(99) < 5) begin
                logic [63:0] rpc;
                rpc = {$urandom, $urandom};
                if ($urandom_range(3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | rpc[3:0];
                rpc[1:0] = 2'b00;
                step(1'b1, rpc);
            end else begin
                step(1'b0, '0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
